pc_redirect_unit: RTL and testbench
===================================

// Module: pc_redirect_unit
// PURPOSE
//   Owns the fetch PC. Consumes the taken/not-taken result of the branch-condition
//   stage in EX and redirects fetch. Predict-not-taken; a taken branch/jump is a
//   redirect that squashes the younger IF/ID and ID/EX contents.
//   Holds a redirect while instruction memory is busy, freezes on HALT, and counts
//   redirects for performance.
// PARAMETERS
//   ADDR_W    16     PC / address width
//   RESET_PC  16'h0  PC value loaded on reset
//   CNT_W     16     width of the saturating redirect counter
// PORTS
//   clk            in   1       clock, all state updates on rising edge
//   rst            in   1       synchronous active-high reset
//   ex_valid       in   1       EX stage holds a valid (non-bubble) instruction
//   ex_is_ctrl     in   1       EX instruction is a branch or jump
//   brch_taken     in   1       branch-condition result for EX instruction (1 = taken)
//   brch_target    in   ADDR_W  resolved target address of EX instruction
//   ex_halt        in   1       EX instruction is HALT
//   hazard_stall   in   1       load-use stall from hazard unit: hold PC
//   fetch_stall    in   1       instruction memory busy: PC cannot change this cycle
//   pc             out  ADDR_W  current fetch PC (registered)
//   flush_ifid     out  1       squash IF/ID contents this cycle
//   flush_idex     out  1       squash ID/EX contents this cycle
//   redirect_busy  out  1       a redirect is latched and waiting on fetch_stall
//   halted         out  1       HALT has retired through EX; PC frozen
//   redirect_cnt   out  CNT_W   count of accepted redirects, saturating
// BEHAVIOUR
//   Reset: pc=RESET_PC, state=RUN, pend_tgt=0, redirect_cnt=0.
//     Reset also forces every flag output to 0: flush_ifid, flush_idex,
//     redirect_busy and halted.
//   take = ex_valid & ex_is_ctrl & brch_taken. Only evaluated in RUN.
//   States: RUN, PEND, HALT.
//   RUN, priority order within a cycle:
//     1) take & !fetch_stall: pc<=brch_target next edge. flush_ifid=flush_idex=1
//        (combinational, same cycle as take). redirect_cnt++. Stay in RUN.
//     2) take & fetch_stall: pend_tgt<=brch_target; ->PEND. flush_ifid=flush_idex=1
//        this cycle. redirect_cnt++. pc held.
//     3) ex_valid & ex_halt (not take): ->HALT. pc held.
//     4) fetch_stall | hazard_stall: pc held. No flush.
//     5) else pc<=pc+2, modulo 2^ADDR_W (0xFFFE wraps to 0x0000).
//     - take overrides hazard_stall: the stalled instruction is younger and is squashed.
//   PEND:
//     - redirect_busy=1, flush_ifid=1 every cycle; flush_idex=0.
//     - ex_valid and all EX inputs ignored (wrong-path); hazard_stall ignored.
//     - If fetch_stall=0: pc<=pend_tgt; ->RUN. redirect_busy=0 from next cycle.
//   HALT:
//     - halted=1, pc frozen, no flushes, redirect_cnt frozen. Exit only via rst.
//   Outputs outside the cases above are 0.
//   redirect_cnt saturates at 2^CNT_W-1; further redirects leave it unchanged.
//   Not-taken branches and bubbles (ex_valid=0) never redirect or count.
//   rst asserted in any state, including mid-PEND, wins. It discards pend_tgt and
//     returns to the reset values on the next edge.
//   Latency: taken resolved in cycle N -> pc=target visible in cycle N+1
//     (N+k+1 if fetch_stall held for k cycles).
// TESTING
//   T1 reset then 4 free cycles -> pc 0,2,4,6,8. Flags 0, redirect_cnt=0.
//   T2 pc=0x0010, taken to 0x0040, no stalls -> flush_ifid=flush_idex=1 that cycle.
//      Next cycle pc=0x0040, redirect_cnt=1.
//   T3 taken to 0x0100 with fetch_stall=1 for 3 cycles -> PEND, redirect_busy=1,
//      flush_ifid=1 throughout. Spurious ex_valid/take during PEND ignored.
//      pc=0x0100 one cycle after fetch_stall drops, redirect_cnt=1.
//   T4 hazard_stall=1 & take to 0x0200 same cycle -> next pc=0x0200.
//      hazard_stall alone -> pc held, no flush.
//   T5 pc=0xFFFE free-running -> pc=0x0000. ex_halt -> halted=1, pc frozen 10 cycles.
//      rst -> pc=RESET_PC, halted=0.
//   T6 CNT_W=2: 5 taken redirects -> redirect_cnt 1,2,3,3,3.
//      rst during PEND -> pc=RESET_PC, redirect_busy=0, pend target discarded.

Source files
------------

// File: rtl/pc_redirect_unit_if.sv
// Fetch-redirect bus: EX-stage branch resolution and stall inputs in,
// fetch PC, pipeline flushes and status out.
interface pc_redirect_unit_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
);
  logic              ex_valid;
  logic              ex_is_ctrl;
  logic              brch_taken;
  logic [ADDR_W-1:0] brch_target;
  logic              ex_halt;
  logic              hazard_stall;
  logic              fetch_stall;
  logic [ADDR_W-1:0] pc;
  logic              flush_ifid;
  logic              flush_idex;
  logic              redirect_busy;
  logic              halted;
  logic [CNT_W-1:0]  redirect_cnt;

  modport slave (
    input  ex_valid, ex_is_ctrl, brch_taken, brch_target, ex_halt,
           hazard_stall, fetch_stall,
    output pc, flush_ifid, flush_idex, redirect_busy, halted, redirect_cnt
  );

  modport master (
    output ex_valid, ex_is_ctrl, brch_taken, brch_target, ex_halt,
           hazard_stall, fetch_stall,
    input  pc, flush_ifid, flush_idex, redirect_busy, halted, redirect_cnt
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: predict-not-taken, redirects on taken EX control flow,
// parks a redirect while imem is busy, freezes on HALT, counts redirects.
module pc_redirect_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  pc_redirect_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PEND = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              take;
  logic              flush_ifid_c;
  logic              flush_idex_c;

  assign take = bus.ex_valid & bus.ex_is_ctrl & bus.brch_taken;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_tgt_d   = pend_tgt_q;
    cnt_d        = cnt_q;
    flush_ifid_c = 1'b0;
    flush_idex_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        // take outranks both stalls: the stalled instruction is younger and dies anyway
        if (take) begin
          flush_ifid_c = 1'b1;
          flush_idex_c = 1'b1;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          if (!bus.fetch_stall) begin
            pc_d = bus.brch_target;
          end else begin
            pend_tgt_d = bus.brch_target;
            state_d    = ST_PEND;
          end
        end else if (bus.ex_valid && bus.ex_halt) begin
          state_d = ST_HALT;
        end else if (!(bus.fetch_stall || bus.hazard_stall)) begin
          pc_d = pc_q + ADDR_W'(2);
        end
      end
      ST_PEND: begin
        // everything in EX now is wrong-path; keep squashing the fetch side
        flush_ifid_c = 1'b1;
        if (!bus.fetch_stall) begin
          pc_d    = pend_tgt_q;
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      pend_tgt_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.redirect_cnt  = cnt_q;
  assign bus.flush_ifid    = flush_ifid_c & ~rst;
  assign bus.flush_idex    = flush_idex_c & ~rst;
  assign bus.redirect_busy = (state_q == ST_PEND) & ~rst;
  assign bus.halted        = (state_q == ST_HALT) & ~rst;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed + random bench for pc_redirect_unit; two instances (16-bit and
// 2-bit counter) share stimulus and are checked against one behavioural model.
module tb_pc_redirect_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_redirect_unit_if #(.ADDR_W(16), .CNT_W(16)) u_if ();
  pc_redirect_unit_if #(.ADDR_W(16), .CNT_W(2))  u_if2 ();

  assign u_if2.ex_valid     = u_if.ex_valid;
  assign u_if2.ex_is_ctrl   = u_if.ex_is_ctrl;
  assign u_if2.brch_taken   = u_if.brch_taken;
  assign u_if2.brch_target  = u_if.brch_target;
  assign u_if2.ex_halt      = u_if.ex_halt;
  assign u_if2.hazard_stall = u_if.hazard_stall;
  assign u_if2.fetch_stall  = u_if.fetch_stall;

  pc_redirect_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  pc_redirect_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (u_if2.slave)
  );

  int checks = 0;
  int errors = 0;

  // behavioural model: PC as an integer, a "redirect owed" flag, a halted flag
  int m_pc   = 0;
  int m_tgt  = 0;
  bit m_pend = 1'b0;
  bit m_halt = 1'b0;
  int m_cnt16 = 0;
  int m_cnt2  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input bit v, input bit c, input bit t,
                       input int tg, input bit h, input bit hs, input bit fs);
    rst               = r;
    u_if.ex_valid     = v;
    u_if.ex_is_ctrl   = c;
    u_if.brch_taken   = t;
    u_if.brch_target  = 16'(tg);
    u_if.ex_halt      = h;
    u_if.hazard_stall = hs;
    u_if.fetch_stall  = fs;
  endtask

  // compare this cycle's outputs, clock once, then advance the model
  task automatic cycle();
    bit running, tk, e_fi, e_fx;
    #1;
    running = !m_pend && !m_halt;
    tk   = running && u_if.ex_valid && u_if.ex_is_ctrl && u_if.brch_taken;
    e_fi = !rst && (tk || m_pend);
    e_fx = !rst && tk;
    check("pc",            int'(u_if.pc),            m_pc);
    check("flush_ifid",    int'(u_if.flush_ifid),    int'(e_fi));
    check("flush_idex",    int'(u_if.flush_idex),    int'(e_fx));
    check("redirect_busy", int'(u_if.redirect_busy), int'(!rst && m_pend));
    check("halted",        int'(u_if.halted),        int'(!rst && m_halt));
    check("cnt16",         int'(u_if.redirect_cnt),  m_cnt16);
    check("cnt2",          int'(u_if2.redirect_cnt), m_cnt2);
    check("pc2",           int'(u_if2.pc),           m_pc);
    @(posedge clk);
    if (rst) begin
      m_pc = 0; m_tgt = 0; m_pend = 0; m_halt = 0; m_cnt16 = 0; m_cnt2 = 0;
    end else if (m_halt) begin
      m_pc = m_pc;
    end else if (m_pend) begin
      if (!u_if.fetch_stall) begin
        m_pc = m_tgt;
        m_pend = 0;
      end
    end else if (tk) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt2 < 3) m_cnt2++;
      if (!u_if.fetch_stall) m_pc = int'(u_if.brch_target);
      else begin
        m_tgt = int'(u_if.brch_target);
        m_pend = 1;
      end
    end else if (u_if.ex_valid && u_if.ex_halt) begin
      m_halt = 1;
    end else if (!(u_if.fetch_stall || u_if.hazard_stall)) begin
      m_pc = (m_pc + 2) % 65536;
    end
    @(negedge clk);
  endtask

  task automatic free_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cycle();

    // T1: free-running from reset
    free_cycles(4);
    check("t1_pc_after4", int'(u_if.pc), 16'h0008);
    check("t1_cnt", int'(u_if.redirect_cnt), 0);
    free_cycles(4);

    // T2: taken at pc 0x0010 -> 0x0040
    check("t2_pc_before", int'(u_if.pc), 16'h0010);
    drive(0, 1, 1, 1, 16'h0040, 0, 0, 0);
    #1;
    check("t2_flush_ifid", int'(u_if.flush_ifid), 1);
    check("t2_flush_idex", int'(u_if.flush_idex), 1);
    cycle();
    check("t2_pc", int'(u_if.pc), 16'h0040);
    check("t2_cnt", int'(u_if.redirect_cnt), 1);

    // T3: redirect held by fetch_stall, spurious takes ignored while pending
    drive(0, 1, 1, 1, 16'h0100, 0, 0, 1);
    cycle();
    check("t3_busy", int'(u_if.redirect_busy), 1);
    drive(0, 1, 1, 1, 16'h0300, 0, 1, 1);
    cycle();
    drive(0, 1, 1, 1, 16'h0300, 1, 0, 1);
    cycle();
    check("t3_pc_held", int'(u_if.pc), 16'h0040);
    drive(0, 1, 1, 1, 16'h0300, 0, 0, 0);
    cycle();
    check("t3_pc", int'(u_if.pc), 16'h0100);
    check("t3_cnt", int'(u_if.redirect_cnt), 2);
    check("t3_busy_clear", int'(u_if.redirect_busy), 0);

    // T4: take beats hazard_stall; hazard_stall alone holds without flush
    drive(0, 1, 1, 1, 16'h0200, 0, 1, 0);
    cycle();
    check("t4_pc", int'(u_if.pc), 16'h0200);
    drive(0, 1, 1, 0, 16'h0600, 0, 1, 0);
    #1;
    check("t4_no_flush", int'(u_if.flush_ifid), 0);
    cycle();
    cycle();
    check("t4_pc_held", int'(u_if.pc), 16'h0200);

    // T6a: 2-bit counter saturates while the 16-bit one keeps counting
    check("t6_cnt2_sat", int'(u_if2.redirect_cnt), 3);
    drive(0, 1, 1, 1, 16'h0700, 0, 0, 0);
    cycle();
    cycle();
    check("t6_cnt2_still", int'(u_if2.redirect_cnt), 3);
    check("t6_cnt16", int'(u_if.redirect_cnt), 5);

    // T5: wrap at 0xFFFE, then HALT freezes everything until reset
    drive(0, 1, 1, 1, 16'hFFFE, 0, 0, 0);
    cycle();
    free_cycles(1);
    check("t5_wrap", int'(u_if.pc), 16'h0000);
    free_cycles(1);
    drive(0, 1, 0, 0, 0, 1, 0, 0);
    cycle();
    check("t5_halted", int'(u_if.halted), 1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 1, 1, 16'h0800, 0, 0, 0);
      cycle();
    end
    check("t5_pc_frozen", int'(u_if.pc), 16'h0002);
    check("t5_cnt_frozen", int'(u_if.redirect_cnt), 6);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    check("t5_reset_pc", int'(u_if.pc), 16'h0000);
    check("t5_reset_halted", int'(u_if.halted), 0);

    // T6b: reset during PEND discards the parked target
    free_cycles(2);
    drive(0, 1, 1, 1, 16'h0500, 0, 0, 1);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    check("t6_rst_pc", int'(u_if.pc), 16'h0000);
    check("t6_rst_busy", int'(u_if.redirect_busy), 0);
    free_cycles(1);
    check("t6_no_stale_tgt", int'(u_if.pc), 16'h0002);

    // random phase against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 39) == 0,
            ($urandom % 4) != 0,
            ($urandom % 2) != 0,
            ($urandom % 2) != 0,
            int'(16'($urandom) & 16'hFFFE),
            $urandom_range(0, 24) == 0,
            ($urandom % 5) == 0,
            ($urandom % 3) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
